// File: rtl/control_sequencer.sv
// control_sequencer -- multi-cycle fetch/decode/execute sequencer for the
// accumulator CPU datapath. Issues one 14-bit control word per cycle.
//
// Adds a memory-ready wait-state handshake (F2/A2/MR/MW hold until mem_ready),
// an explicit HALT/start flow, illegal-opcode trapping, and an optional
// memory-timeout trap enabled by defining CTRL_MEM_TIMEOUT_EN.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        leave IDLE/HALT and begin fetching (level)
//   opcode       instruction register opcode (OPW bits)
//   flag         accumulator-nonzero flag for JPNZ
//   mem_ready    memory completes the current access this cycle
//   signals      control word {ar_ld_pc, ar_ld_dr, pc_inc, pc_ld_dr, ir_ld,
//                mem_rd, dr_ld_mem, ac_ld_dr, mem_wr, ac_clr, rsvd, alu_op[2:0]}
//   busy         state is not IDLE/HALT/TRAP
//   halted       state is HALT
//   trap         state is TRAP
//   trap_cause   01 illegal opcode, 10 memory timeout, 00 none
module control_sequencer #(
  parameter int OPW      = 4,
  parameter int WAIT_MAX = 15,
  parameter int WAIT_W   = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [OPW-1:0] opcode,
  input  logic           flag,
  input  logic           mem_ready,
  output logic [13:0]    signals,
  output logic           busy,
  output logic           halted,
  output logic           trap,
  output logic [1:0]     trap_cause
);

  localparam int B_AR_LD_PC  = 13;
  localparam int B_AR_LD_DR  = 12;
  localparam int B_PC_INC    = 11;
  localparam int B_PC_LD_DR  = 10;
  localparam int B_IR_LD     = 9;
  localparam int B_MEM_RD    = 8;
  localparam int B_DR_LD_MEM = 7;
  localparam int B_AC_LD_DR  = 6;
  localparam int B_MEM_WR    = 5;
  localparam int B_AC_CLR    = 4;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_INC = 3'b011;
  localparam logic [2:0] ALU_SHF = 3'b100;

  localparam logic [3:0] OP_HALT  = 4'd0;
  localparam logic [3:0] OP_READ  = 4'd1;
  localparam logic [3:0] OP_WRITE = 4'd2;
  localparam logic [3:0] OP_JPNZ  = 4'd3;
  localparam logic [3:0] OP_CLAC  = 4'd4;
  localparam logic [3:0] OP_ADD   = 4'd5;
  localparam logic [3:0] OP_SUB   = 4'd6;
  localparam logic [3:0] OP_SHIFT = 4'd7;
  localparam logic [3:0] OP_INC   = 4'd8;

  localparam logic [1:0] CAUSE_ILL = 2'b01;
  localparam logic [1:0] CAUSE_TMO = 2'b10;

  if ((1 << WAIT_W) <= WAIT_MAX) begin : g_cfg_err
    $error("control_sequencer: WAIT_W too narrow for WAIT_MAX");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_F1, S_F2, S_DEC, S_A1, S_A2, S_A3, S_MR,
    S_AL, S_MW, S_EX, S_JMP, S_SKIP, S_HALT, S_TRAP
  } state_t;

  state_t     state, state_n;
  logic [3:0] op_q;      // opcode captured in DEC; EX decodes from this
  logic [1:0] cause_n;
  logic       op_legal;

  // Bits above [3:0] must be zero, and only 0..8 are defined.
  assign op_legal = ((opcode >> 4) == '0) && (opcode[3:0] <= OP_INC);

`ifdef CTRL_MEM_TIMEOUT_EN
  logic [WAIT_W-1:0] wcnt;
  logic              wait_st;
  logic              tmo;

  assign wait_st = (state == S_F2) || (state == S_A2) ||
                   (state == S_MR) || (state == S_MW);
  // wcnt counts earlier low cycles, so this is the WAIT_MAX-th low cycle.
  assign tmo = wait_st && !mem_ready && (wcnt == WAIT_W'(WAIT_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    wcnt <= '0;
    else if (state_n != state)     wcnt <= '0;
    else if (wait_st && !mem_ready) wcnt <= wcnt + 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      op_q       <= '0;
      trap_cause <= 2'b00;
    end else begin
      state <= state_n;
      if (state == S_DEC) op_q <= opcode[3:0];
      if (state_n == S_TRAP && state != S_TRAP) trap_cause <= cause_n;
    end
  end

  always_comb begin
    state_n = state;
    signals = '0;
    cause_n = CAUSE_ILL;
    unique case (state)
      S_IDLE, S_HALT: if (start) state_n = S_F1;
      S_F1: begin
        signals[B_AR_LD_PC] = 1'b1;
        state_n = S_F2;
      end
      S_F2: begin
        signals[B_MEM_RD] = 1'b1;
        if (mem_ready) begin
          signals[B_IR_LD]  = 1'b1;
          signals[B_PC_INC] = 1'b1;
          state_n = S_DEC;
        end
      end
      S_DEC: begin
        if (!op_legal) state_n = S_TRAP;
        else begin
          unique case (opcode[3:0])
            OP_HALT:           state_n = S_HALT;
            OP_READ, OP_WRITE: state_n = S_A1;
            OP_JPNZ:           state_n = flag ? S_A1 : S_SKIP;
            default:           state_n = S_EX;
          endcase
        end
      end
      S_A1: begin
        signals[B_AR_LD_PC] = 1'b1;
        state_n = S_A2;
      end
      S_A2: begin
        signals[B_MEM_RD] = 1'b1;
        if (mem_ready) begin
          signals[B_DR_LD_MEM] = 1'b1;
          signals[B_PC_INC]    = 1'b1;
          state_n = (opcode[3:0] == OP_JPNZ) ? S_JMP : S_A3;
        end
      end
      S_A3: begin
        signals[B_AR_LD_DR] = 1'b1;
        state_n = (opcode[3:0] == OP_READ) ? S_MR : S_MW;
      end
      S_MR: begin
        signals[B_MEM_RD] = 1'b1;
        if (mem_ready) begin
          signals[B_DR_LD_MEM] = 1'b1;
          state_n = S_AL;
        end
      end
      S_AL: begin
        signals[B_AC_LD_DR] = 1'b1;
        state_n = S_F1;
      end
      S_MW: begin
        signals[B_MEM_WR] = 1'b1;
        if (mem_ready) state_n = S_F1;
      end
      S_EX: begin
        unique case (op_q)
          OP_CLAC:  signals[B_AC_CLR] = 1'b1;
          OP_ADD:   signals[2:0] = ALU_ADD;
          OP_SUB:   signals[2:0] = ALU_SUB;
          OP_SHIFT: signals[2:0] = ALU_SHF;
          OP_INC:   signals[2:0] = ALU_INC;
          default:  signals[2:0] = 3'b000;
        endcase
        state_n = S_F1;
      end
      S_JMP: begin
        signals[B_PC_LD_DR] = 1'b1;
        state_n = S_F1;
      end
      S_SKIP: begin
        signals[B_PC_INC] = 1'b1;
        state_n = S_F1;
      end
      S_TRAP:  state_n = S_TRAP;
      default: state_n = S_IDLE;
    endcase
`ifdef CTRL_MEM_TIMEOUT_EN
    // A completing access (mem_ready=1) never times out.
    if (tmo) begin
      state_n = S_TRAP;
      cause_n = CAUSE_TMO;
    end
`endif
  end

  assign busy   = (state != S_IDLE) && (state != S_HALT) && (state != S_TRAP);
  assign halted = (state == S_HALT);
  assign trap   = (state == S_TRAP);

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  opcode = '0;
  logic        flag = 1'b0;
  logic        mem_ready = 1'b1;
  logic [13:0] signals;
  logic        busy, halted, trap;
  logic [1:0]  trap_cause;

  int n_tests = 0;
  int n_fail  = 0;

  control_sequencer #(.OPW(4), .WAIT_MAX(15), .WAIT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .flag(flag),
    .mem_ready(mem_ready), .signals(signals), .busy(busy), .halted(halted),
    .trap(trap), .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    // reset state
    #12;
    chk("rst_sig", 32'(signals), 32'h0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_halt", 32'(halted), 0);
    chk("rst_trap", 32'({trap, trap_cause}), 0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 0);

    // ADD: F1, F2, DEC, EX
    start = 1'b1; opcode = 4'd5;
    tick(); start = 1'b0;
    chk("add_f1", 32'(signals), 32'h2000);
    chk("add_busy", 32'(busy), 1);
    tick(); chk("add_f2", 32'(signals), 32'h0B00);
    tick(); chk("add_dec", 32'(signals), 32'h0000);
    tick(); chk("add_ex", 32'(signals), 32'h0001);
    tick(); chk("add_f1b", 32'(signals), 32'h2000);

    // READ with 3 low cycles in MR (11 cycles total)
    opcode = 4'd1;
    tick(); chk("rd_f2", 32'(signals), 32'h0B00);
    tick(); chk("rd_dec", 32'(signals), 32'h0000);
    tick(); chk("rd_a1", 32'(signals), 32'h2000);
    tick(); chk("rd_a2", 32'(signals), 32'h0980);
    tick(); chk("rd_a3", 32'(signals), 32'h1000);
    tick(); mem_ready = 1'b0; #1 chk("rd_mr_w1", 32'(signals), 32'h0100);
    tick(); chk("rd_mr_w2", 32'(signals), 32'h0100);
    tick(); chk("rd_mr_w3", 32'(signals), 32'h0100);
    tick(); mem_ready = 1'b1; #1 chk("rd_mr_go", 32'(signals), 32'h0180);
    tick(); chk("rd_al", 32'(signals), 32'h0040);
    tick(); chk("rd_f1", 32'(signals), 32'h2000);

    // JPNZ not taken
    opcode = 4'd3; flag = 1'b0;
    tick(); tick(); chk("jn_dec", 32'(signals), 32'h0000);
    tick(); chk("jn_skip", 32'(signals), 32'h0800);
    tick(); chk("jn_f1", 32'(signals), 32'h2000);

    // JPNZ taken
    flag = 1'b1;
    tick(); tick();
    tick(); chk("jt_a1", 32'(signals), 32'h2000);
    tick(); chk("jt_a2", 32'(signals), 32'h0980);
    tick(); chk("jt_jmp", 32'(signals), 32'h0400);
    tick(); chk("jt_f1", 32'(signals), 32'h2000);

    // WRITE, then async reset while waiting in MW
    opcode = 4'd2; flag = 1'b0;
    tick(); tick(); tick(); tick();
    tick(); chk("wr_a3", 32'(signals), 32'h1000);
    tick(); mem_ready = 1'b0; #1 chk("wr_mw", 32'(signals), 32'h0020);
    #2 rst_n = 1'b0; #1;
    chk("wr_rst_sig", 32'(signals), 32'h0);
    chk("wr_rst_busy", 32'(busy), 0);
    chk("wr_rst_trap", 32'(trap), 0);
    rst_n = 1'b1; mem_ready = 1'b1;
    tick(); chk("wr_idle", 32'(busy), 0);

    // HALT: reaches HALT after 3 cycles, waits for start
    opcode = 4'd0; start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    tick(); chk("hlt_halted", 32'(halted), 1);
    chk("hlt_sig", 32'(signals), 32'h0);
    chk("hlt_busy", 32'(busy), 0);
    tick(); chk("hlt_hold", 32'(halted), 1);
    start = 1'b1;
    tick(); start = 1'b0;
    chk("hlt_resume", 32'(signals), 32'h2000);
    chk("hlt_clear", 32'(halted), 0);

    // Illegal opcode traps; start ignored; reset clears
    opcode = 4'd12;
    tick(); tick();
    tick(); chk("ill_trap", 32'({trap, trap_cause}), 32'h5);
    start = 1'b1;
    tick(); tick();
    chk("ill_hold", 32'({trap, trap_cause, signals}), 32'h14000);
    start = 1'b0;
    rst_n = 1'b0; #1;
    chk("ill_rst", 32'({trap, trap_cause, busy}), 0);
    rst_n = 1'b1;

`ifdef CTRL_MEM_TIMEOUT_EN
    // 14 low cycles then ready on the 15th completes
    opcode = 4'd5; start = 1'b1;
    tick(); start = 1'b0;
    tick(); mem_ready = 1'b0;
    for (int i = 1; i < 14; i++) tick();
    tick(); mem_ready = 1'b1; #1 chk("tmo_edge_go", 32'(signals), 32'h0B00);
    tick(); chk("tmo_edge_dec", 32'({trap, signals}), 32'h0);
    tick(); tick();
    // F1 now; 15 low cycles in F2 traps
    tick(); mem_ready = 1'b0;
    for (int i = 1; i < 15; i++) tick();
    chk("tmo_pre", 32'(trap), 0);
    tick(); chk("tmo_trap", 32'({trap, trap_cause}), 32'h6);
    mem_ready = 1'b1;
`else
    // No timeout: waits indefinitely in F2
    opcode = 4'd5; start = 1'b1;
    tick(); start = 1'b0;
    tick(); mem_ready = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("nt_wait", 32'({trap, signals}), 32'h0100);
    mem_ready = 1'b1; #1 chk("nt_go", 32'(signals), 32'h0B00);
    tick(); chk("nt_dec", 32'({trap, trap_cause, signals}), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
# control_sequencer

Parametrised multi-cycle control sequencer for the accumulator CPU datapath. Each instruction is fetched, decoded and executed by issuing a 14-bit control word per cycle. The block adds four things: a memory-ready wait-state handshake, an explicit HALT/start flow, illegal-opcode trapping, and an optional memory-timeout trap. It sits between the instruction register/flag logic and the datapath load/ALU enables.

## Interface
- OPW, 4 — opcode width (≥4); opcode bits above [3:0] must be zero or the opcode is illegal.
- WAIT_MAX, 15 — maximum consecutive cycles a memory state may be held with mem_ready low (timeout build only).
- WAIT_W, 4 — wait-counter width; must satisfy 2^WAIT_W > WAIT_MAX.

Ports:
- clk  in  1  — clock; all state changes on the rising edge.
- rst_n  in  1  — reset, asynchronous, active-low.
- start  in  1  — leave IDLE/HALT and begin fetching.
- opcode  in  OPW  — current instruction register opcode.
- flag  in  1  — accumulator-nonzero flag, used by JPNZ.
- mem_ready  in  1  — memory completes the current read/write this cycle.
- signals  out  14  — control word, combinational from state and mem_ready.
- busy  out  1  — state is not IDLE, HALT or TRAP.
- halted  out  1  — state is HALT.
- trap  out  1  — state is TRAP.
- trap_cause  out  2  — 01 = illegal opcode, 10 = memory timeout, 00 = none.

## Operation
- Control word bits: [13] ar_ld_pc, [12] ar_ld_dr, [11] pc_inc, [10] pc_ld_dr, [9] ir_ld, [8] mem_rd, [7] dr_ld_mem, [6] ac_ld_dr, [5] mem_wr, [4] ac_clr, [3] reserved (always 0), [2:0] alu_op.
- alu_op encoding: 001 ADD, 010 SUB, 011 INC, 100 SHIFT, 000 none.
- Opcodes: 0 HALT, 1 READ, 2 WRITE, 3 JPNZ, 4 CLAC, 5 ADD, 6 SUB, 7 SHIFT, 8 INC. Opcodes 9–15 are illegal.
- States and the control bits each one asserts:
  - IDLE: no bits asserted. Goes to F1 when start=1.
  - F1: ar_ld_pc. Goes to F2.
  - F2: mem_rd. When mem_ready=1, also asserts ir_ld and pc_inc, and goes to DEC.
  - DEC: no bits asserted. Branches on opcode:
    - HALT → HALT.
    - READ, WRITE → A1.
    - JPNZ with flag=1 → A1.
    - JPNZ with flag=0 → SKIP.
    - CLAC, ADD, SUB, SHIFT, INC → EX.
    - Illegal → TRAP with cause 01.
  - A1: ar_ld_pc. Goes to A2.
  - A2: mem_rd. When mem_ready=1, also asserts dr_ld_mem and pc_inc; goes to JMP for JPNZ, otherwise A3.
  - A3: ar_ld_dr. Goes to MR for READ, MW for WRITE.
  - MR: mem_rd. When mem_ready=1, also asserts dr_ld_mem and goes to AL.
  - AL: ac_ld_dr. Goes to F1.
  - MW: mem_wr. When mem_ready=1, goes to F1.
  - EX: ac_clr (CLAC) or the matching alu_op. Goes to F1.
  - JMP: pc_ld_dr. Goes to F1.
  - SKIP: pc_inc, to step over the operand word. Goes to F1.
  - HALT: no bits asserted. Goes to F1 when start=1.
  - TRAP: no bits asserted. Held until reset; start is ignored.
- Wait states are F2, A2, MR and MW. With mem_ready=0 the sequencer stays in the state and holds mem_rd/mem_wr. The load/increment bits are asserted only in the cycle mem_ready=1.
- The opcode is sampled only in DEC and A2/A3; opcode changes in other states have no effect.

## Timing
- Reset: state=IDLE, signals=0, busy=0, halted=0, trap=0, trap_cause=00, wait counter=0. Reset applies immediately at any point, including mid-instruction or during a wait.
- Instruction lengths with mem_ready tied high:
  - CLAC/ADD/SUB/SHIFT/INC: 4 cycles.
  - JPNZ not taken: 4 cycles.
  - JPNZ taken: 6 cycles.
  - WRITE: 7 cycles.
  - READ: 8 cycles.
  - HALT: 3 cycles to reach HALT.
- Each low cycle of mem_ready in a wait state adds exactly one cycle.
- start is a level input, checked only in IDLE/HALT. Transition to F1 happens on the next edge.
- trap_cause is registered on entry to TRAP and holds until reset.

## Configuration
- CTRL_MEM_TIMEOUT_EN defined:
  - The wait counter increments on each mem_ready=0 cycle in a wait state and clears on any state change.
  - If the WAIT_MAX-th consecutive cycle in a wait state also has mem_ready=0, the next state is TRAP with cause 10.
  - If mem_ready=1 in that same cycle, the access completes normally.
- CTRL_MEM_TIMEOUT_EN undefined:
  - No wait counter is built; the sequencer waits indefinitely.
  - trap_cause 10 is never produced.

## Test plan
- Reset, start=1, opcode=5, mem_ready=1 → signals sequence 0x2000, 0x0B00, 0x0000, 0x0001, back to F1. busy=1 from the cycle after start.
- READ with mem_ready low for 3 cycles in MR → 11 cycles total, dr_ld_mem pulses exactly once, then ac_ld_dr (0x0040) in AL.
- JPNZ with flag=0 → SKIP asserts 0x0800 and returns to F1 after 4 cycles. JPNZ with flag=1 → JMP asserts 0x0400 at cycle 6.
- opcode=0 → halted=1 and signals=0 until start=1. opcode=12 → trap=1, trap_cause=01; a later start is ignored and rst_n low clears it.
- Timeout build, WAIT_MAX=15:
  - mem_ready low for 14 cycles in F2, high on the 15th → fetch completes.
  - mem_ready low for 15 cycles → trap=1, trap_cause=10 on the next cycle.
- rst_n asserted mid-MW while mem_wr=1 → signals=0 immediately (asynchronously), state IDLE, no trap.
